// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide unit with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, sign fix-up in FIX.
module mdu_ctrl #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [5:0]   i_funct,
  input  logic [N-1:0] i_rs,
  input  logic [N-1:0] i_rt,
  input  logic         i_flush,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo,
  output logic [N-1:0] o_result
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] CNT_INIT = 6'(N);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [N-1:0]   a_q, a_d;
  logic [2*N-1:0] p_q, p_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic           dz_q, dz_d;
  logic           op_div_q, op_div_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic           is_mul, is_div, is_signed;
  logic [N-1:0]   mag_rs, mag_rt;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_cand, div_diff;
  logic [N-1:0]   div_rem;
  logic [2*N-1:0] div_next;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  assign is_mul    = (i_funct == F_MULT) || (i_funct == F_MULTU);
  assign is_div    = (i_funct == F_DIV)  || (i_funct == F_DIVU);
  assign is_signed = ~i_funct[0];
  assign mag_rs    = (is_signed && i_rs[N-1]) ? -i_rs : i_rs;
  assign mag_rt    = (is_signed && i_rt[N-1]) ? -i_rt : i_rt;

  // Multiplier sits in the low half of p_q and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, p_q[2*N-1:N]} + {1'b0, a_q};
  assign mul_next = p_q[0] ? {mul_sum, p_q[N-1:1]} : {1'b0, p_q[2*N-1:1]};

  // p_q holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign div_cand = p_q[2*N-1:N-1];
  assign div_diff = div_cand - {1'b0, a_q};
  assign div_rem  = div_diff[N] ? div_cand[N-1:0] : div_diff[N-1:0];
  assign div_next = {div_rem, p_q[N-2:0], ~div_diff[N]};

  assign prod_fix = neg_q  ? -p_q : p_q;
  assign quo_fix  = dz_q ? {N{1'b1}} : (neg_q ? -p_q[N-1:0] : p_q[N-1:0]);
  assign rem_fix  = rneg_q ? -p_q[2*N-1:N] : p_q[2*N-1:N];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    p_d      = p_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    op_div_d = op_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && (is_mul || is_div)) begin
            state_d  = is_mul ? MUL : DIV;
            cnt_d    = CNT_INIT;
            a_d      = is_mul ? mag_rs : mag_rt;
            p_d      = {{N{1'b0}}, (is_mul ? mag_rt : mag_rs)};
            neg_d    = is_signed && (i_rs[N-1] ^ i_rt[N-1]);
            rneg_d   = is_signed && i_rs[N-1];
            dz_d     = (i_rt == '0);
            op_div_d = is_div;
          end else if (i_start && i_funct == F_MTHI) begin
            hi_d = i_rs;
          end else if (i_start && i_funct == F_MTLO) begin
            lo_d = i_rs;
          end
        end
        MUL, DIV: begin
          p_d   = (state_q == MUL) ? mul_next : div_next;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = FIX;
        end
        FIX: begin
          if (op_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*N-1:N];
            lo_d = prod_fix[N-1:0];
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      op_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      p_q      <= p_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      op_div_q <= op_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_hi     = hi_q;
  assign o_lo     = lo_q;
  assign o_result = (i_funct == F_MFHI) ? hi_q :
                    (i_funct == F_MFLO) ? lo_q : '0;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter N, default 32, SHALL set operand, HI, LO and result width.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  SHALL be a synchronous, active-low reset.
REQ-004 i_start  input  1  SHALL mark a valid issue in the EX stage.
REQ-005 i_funct  input  6  SHALL be the R-type function code of the issued instruction.
REQ-006 i_rs, i_rt  input  N  SHALL be the forwarded operands: rs is the dividend or multiplicand, rt the divisor or multiplier.
REQ-007 i_flush  input  1  SHALL abort any operation in progress.
REQ-008 o_busy  output  1  SHALL be high while a MULT or DIV operation is in progress; the pipeline stalls on it.
REQ-009 o_done  output  1  SHALL pulse for one cycle when HI and LO hold a new MULT or DIV result.
REQ-010 o_hi, o_lo  output  N  SHALL be the architectural HI and LO registers.
REQ-011 o_result  output  N  SHALL be the MFHI/MFLO read data.

Function
REQ-012 Decode SHALL be: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011; any other i_funct SHALL be ignored.
REQ-013 The FSM SHALL have exactly four states: IDLE, MUL, DIV, FIX.
REQ-014 A MULT* or DIV* operation SHALL be accepted only when state = IDLE, i_start = 1 and i_flush = 0; operands are latched and the FSM moves to MUL or DIV.
REQ-015 i_start while not in IDLE SHALL be ignored; the pipeline is already stalled by o_busy.
REQ-016 MUL SHALL run a radix-2 shift-add on operand magnitudes for exactly N cycles, using a 6-bit down-counter loaded with N.
REQ-017 DIV SHALL run restoring division on magnitudes for exactly N cycles, using the same counter.
REQ-018 MULTU and DIVU SHALL use raw operands; MULT and DIV SHALL take two's-complement magnitudes at accept.
REQ-019 FIX SHALL last one cycle and SHALL write HI/LO:
- MULT: the 2N-bit product is negated when operand signs differ.
- DIV: the quotient (LO) is negated when signs differ; the remainder (HI) takes the dividend's sign.
REQ-020 Divide by zero (DIV or DIVU) SHALL still take full latency and SHALL produce LO = all ones, HI = i_rs as latched.
REQ-021 DIV of -2^(N-1) by -1 SHALL produce LO = 0x80000000 and HI = 0 (N=32).
REQ-022 Latency: for accept at edge k, o_busy SHALL be high in cycles k+1..k+N+1 (MUL/DIV/FIX), and o_done and the new HI/LO SHALL be visible in cycle k+N+2.
REQ-023 o_done SHALL be a registered single-cycle pulse; back-to-back operation is allowed by a new accept in the o_done cycle.
REQ-024 MTHI/MTLO with i_start in IDLE SHALL write i_rs to HI/LO at the next edge, with no o_busy and no o_done.
REQ-025 o_result SHALL be combinational: HI when i_funct = MFHI, LO when i_funct = MFLO, 0 otherwise; during o_busy it is don't-care.
REQ-026 i_flush SHALL force IDLE at the next edge from any state, leave HI/LO unchanged and suppress o_done.
REQ-027 i_flush SHALL block a simultaneous accept or MTHI/MTLO write.
REQ-028 Priority SHALL be: reset > flush > start.

Reset
REQ-029 While i_reset = 0 at an edge, state SHALL become IDLE, HI = LO = 0, the counter and internal registers 0, o_busy = 0, o_done = 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation, with no o_done afterwards.
REQ-031 o_result SHALL read 0 after reset for MFHI and MFLO.

Verification
REQ-032 Reset -> hold i_reset = 0 for 2 cycles mid-DIV -> o_hi = o_lo = 0, o_busy = 0, no o_done.
REQ-033 MULT -> i_rs = 0xFFFFFFFD, i_rt = 7 -> o_busy high for exactly 33 cycles; o_done in cycle 34; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-034 MULTU -> 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-035 DIV and DIVU:
- DIV -7/2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7/0 -> LO = 0xFFFFFFFF, HI = 0x00000007, same latency.
REQ-036 MTHI then MFHI -> MTHI i_rs = 0x00001234, then MFHI -> o_result = 0x00001234; o_busy never asserted.
REQ-037 Flush and back-to-back:
- i_flush in DIV iteration 10 -> IDLE next cycle, HI/LO unchanged, no o_done.
- MULT accepted in an o_done cycle -> second o_done exactly 34 cycles later.
